// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson shift-register sequencer with up/down stepping,
// parallel load, period position tracking, wrap pulse and illegal-state detection.
module ring_johnson_counter #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter bit               AUTOCORRECT = 1'b1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_en,
    input  logic                            i_mode,
    input  logic                            i_dir,
    input  logic                            i_load,
    input  logic [WIDTH-1:0]                i_load_val,
    output logic [WIDTH-1:0]                o_q,
    output logic [$clog2(2*WIDTH)-1:0]      o_pos,
    output logic                            o_wrap,
    output logic                            o_err
);

    localparam int unsigned PW = $clog2(2*WIDTH);
    localparam logic [PW-1:0] RING_LAST = PW'(WIDTH - 1);
    localparam logic [PW-1:0] JOHN_LAST = PW'(2*WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [PW-1:0]    r_pos;
    logic             r_wrap;

    logic [WIDTH-1:0] w_q_nxt;
    logic [PW-1:0]    w_pos_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-2:0] w_trans;
    logic             w_legal;
    logic [PW-1:0]    w_last;
    logic             w_fb_up;
    logic             w_fb_dn;

    // Johnson states have at most one boundary between adjacent bits.
    assign w_trans = r_q[WIDTH-2:0] ^ r_q[WIDTH-1:1];
    assign w_legal = i_mode ? $onehot0(w_trans) : $onehot(r_q);
    assign w_last  = i_mode ? JOHN_LAST : RING_LAST;

    // Johnson feedback is the inverted end bit; ring feedback is the plain end bit.
    assign w_fb_up = r_q[WIDTH-1] ^ i_mode;
    assign w_fb_dn = r_q[0] ^ i_mode;

    always_comb begin
        w_q_nxt    = r_q;
        w_pos_nxt  = r_pos;
        w_wrap_nxt = 1'b0;
        if (i_load) begin
            w_q_nxt   = i_load_val;
            w_pos_nxt = '0;
        end else if (i_en) begin
            if (AUTOCORRECT && !w_legal) begin
                w_q_nxt    = i_mode ? '0 : WIDTH'(1);
                w_pos_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                if (!i_dir) begin
                    w_q_nxt = {r_q[WIDTH-2:0], w_fb_up};
                end else begin
                    w_q_nxt = {w_fb_dn, r_q[WIDTH-1:1]};
                end
                // A position left out of range by a mode switch restarts the period.
                if (r_pos > w_last) begin
                    w_pos_nxt = '0;
                end else if (!i_dir) begin
                    w_pos_nxt = (r_pos == w_last) ? '0 : r_pos + PW'(1);
                end else begin
                    w_pos_nxt = (r_pos == '0) ? w_last : r_pos - PW'(1);
                end
                w_wrap_nxt = (w_pos_nxt == '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q    <= SEED;
            r_pos  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_nxt;
            r_pos  <= w_pos_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign o_q    = r_q;
    assign o_pos  = r_pos;
    assign o_wrap = r_wrap;
    assign o_err  = ~w_legal;

endmodule

// File: tb/tb_ring_johnson_counter.sv
// Directed bench for ring_johnson_counter: two WIDTH=4 instances (self-correcting
// and not) checked every cycle against an arithmetic model plus literal expectations.
module tb_ring_johnson_counter;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en, mode, dir, load;
    logic [3:0] lv;

    logic [3:0] q_a, q_b;
    logic [2:0] pos_a, pos_b;
    logic       wrap_a, wrap_b, err_a, err_b;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    int mq[2];
    int mpos[2];
    int mwrap[2];

    always #5 clk = ~clk;

    ring_johnson_counter #(.WIDTH(4), .SEED(4'b0001), .AUTOCORRECT(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_dir(dir),
        .i_load(load), .i_load_val(lv),
        .o_q(q_a), .o_pos(pos_a), .o_wrap(wrap_a), .o_err(err_a)
    );

    ring_johnson_counter #(.WIDTH(4), .SEED(4'b0001), .AUTOCORRECT(1'b0)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_dir(dir),
        .i_load(load), .i_load_val(lv),
        .o_q(q_b), .o_pos(pos_b), .o_wrap(wrap_b), .o_err(err_b)
    );

    function automatic int bit_of(int v, int i);
        return (v >> i) & 1;
    endfunction

    // Ring: one bit set. Johnson: at most one place where neighbours differ.
    function automatic int legal(int q, bit md);
        int cnt = 0;
        if (!md) begin
            for (int i = 0; i < W; i++) cnt += bit_of(q, i);
            return (cnt == 1) ? 1 : 0;
        end
        for (int i = 0; i < W - 1; i++)
            if (bit_of(q, i) != bit_of(q, i + 1)) cnt++;
        return (cnt <= 1) ? 1 : 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k] = 1; mpos[k] = 0; mwrap[k] = 0;
        end
    endtask

    task automatic model_step();
        int per, fb, mask;
        mask = (1 << W) - 1;
        per  = mode ? 2 * W : W;
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                mq[k] = int'(lv); mpos[k] = 0; mwrap[k] = 0;
            end else if (en) begin
                if (k == 0 && legal(mq[k], mode) == 0) begin
                    mq[k] = mode ? 0 : 1; mpos[k] = 0; mwrap[k] = 1;
                end else begin
                    if (!dir) begin
                        fb = bit_of(mq[k], W - 1);
                        if (mode) fb = 1 - fb;
                        mq[k] = ((mq[k] * 2) & mask) + fb;
                    end else begin
                        fb = bit_of(mq[k], 0);
                        if (mode) fb = 1 - fb;
                        mq[k] = (mq[k] / 2) + fb * (1 << (W - 1));
                    end
                    if (mpos[k] >= per) mpos[k] = 0;
                    else if (!dir)      mpos[k] = (mpos[k] + 1) % per;
                    else                mpos[k] = (mpos[k] + per - 1) % per;
                    mwrap[k] = (mpos[k] == 0) ? 1 : 0;
                end
            end else begin
                mwrap[k] = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("a.q",    int'(q_a),    mq[0]);
            check("a.pos",  int'(pos_a),  mpos[0]);
            check("a.wrap", int'(wrap_a), mwrap[0]);
            check("a.err",  int'(err_a),  1 - legal(mq[0], mode));
            check("b.q",    int'(q_b),    mq[1]);
            check("b.pos",  int'(pos_b),  mpos[1]);
            check("b.wrap", int'(wrap_b), mwrap[1]);
            check("b.err",  int'(err_b),  1 - legal(mq[1], mode));
        end
    end

    task automatic apply(input logic ld, input logic e, input logic md,
                         input logic dr, input logic [3:0] v);
        load = ld; en = e; mode = md; dir = dr; lv = v;
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic lit_a(input string nm, input int eq, input int ep, input int ew);
        check({nm, ".q"},    int'(q_a),    eq);
        check({nm, ".pos"},  int'(pos_a),  ep);
        check({nm, ".wrap"}, int'(wrap_a), ew);
    endtask

    initial begin
        int t1q[4] = '{2, 4, 8, 1};
        int t1p[4] = '{1, 2, 3, 0};
        int t2q[9] = '{1, 3, 7, 15, 14, 12, 8, 0, 1};
        int t3q[3] = '{2, 1, 8};
        int t3p[3] = '{1, 0, 3};

        en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; lv = 4'h0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_on = 1'b1;
        lit_a("rst", 1, 0, 0);
        check("rst.err", int'(err_a), 0);

        // Reset holds outputs even with en asserted.
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("rst_hold", 1, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
            lit_a("ring_up", t1q[i], t1p[i], (i == 3) ? 1 : 0);
            check("ring_up.err", int'(err_a), 0);
        end

        apply(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        lit_a("j_load", 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
            lit_a("john_up", t2q[i], (i + 1) % 8, (i == 7) ? 1 : 0);
        end

        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("pre_down", 4, 2, 0);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
            lit_a("ring_down", t3q[i], t3p[i], (i == 1) ? 1 : 0);
        end

        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);
        check("ill.err_a", int'(err_a), 1);
        check("ill.err_b", int'(err_b), 1);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("fix", 1, 0, 1);
        check("fix.err_a", int'(err_a), 0);
        check("nofix.q",   int'(q_b),   4'b1100);
        check("nofix.err", int'(err_b), 1);

        apply(1'b1, 1'b1, 1'b0, 1'b0, 4'b1000);
        lit_a("load_en", 8, 0, 0);
        check("load_en.b", int'(q_b), 8);

        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
            lit_a("hold", 4, 2, 0);
        end
        mode = 1'b1;
        #1;
        check("mode_sw.err_a", int'(err_a), 1);
        check("mode_sw.err_b", int'(err_b), 1);
        apply(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        lit_a("j_fix", 0, 0, 1);
        check("j_fix.err", int'(err_a), 0);
        check("j_nofix.q", int'(q_b), 4'b1001);
        check("j_nofix.pos", int'(pos_b), 3);

        // Johnson pos 7 is out of range once back in ring mode.
        apply(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 7; i++) apply(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        lit_a("j_pos7", 8, 7, 0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("ring_pos_rst", 1, 0, 1);

        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("pre_rst", 4, 2, 0);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        lit_a("async_rst", 1, 0, 0);
        check("async_rst.b", int'(q_b), 1);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("async_hold", 1, 0, 0);
        rst_n = 1'b1;
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        lit_a("post_rst", 2, 1, 0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
